// File: rtl/sp_ram_arbiter_if.sv
// Two-master request/response bus plus the single-port RAM command port of sp_ram_arbiter.
interface sp_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic                  m0_req_i,    m1_req_i;
  logic                  m0_gnt_o,    m1_gnt_o;
  logic [ADDR_WIDTH-1:0] m0_addr_i,   m1_addr_i;
  logic                  m0_we_i,     m1_we_i;
  logic [BE_W-1:0]       m0_be_i,     m1_be_i;
  logic [DATA_WIDTH-1:0] m0_wdata_i,  m1_wdata_i;
  logic                  m0_rvalid_o, m1_rvalid_o;
  logic [DATA_WIDTH-1:0] m0_rdata_o,  m1_rdata_o;

  logic                  ram_en_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic                  ram_we_o;
  logic [BE_W-1:0]       ram_be_o;
  logic [DATA_WIDTH-1:0] ram_wdata_o;
  logic [DATA_WIDTH-1:0] ram_rdata_i;
  logic                  init_done_o;

  modport slave (
    input  m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
    input  m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o,
    input  ram_rdata_i,
    output init_done_o
  );

  modport master (
    output m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
    output m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o,
    output ram_rdata_i,
    input  init_done_o
  );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two masters, with optional
// zero-fill of the whole RAM after reset.
module sp_ram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 32768,
  parameter int INIT_ZERO  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  sp_ram_arbiter_if.slave bus
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int W     = NUM_WORDS / BE_W;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [0:0] ST_RST  = (INIT_ZERO == 1) ? ST_INIT : ST_RUN;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BE_W-1:0]       be;
    logic [DATA_WIDTH-1:0] wdata;
  } ram_cmd_t;

  logic [0:0]     state;
  logic           armed;
  logic [CNT_W-1:0] cnt;
  logic           prio;
  logic [1:0]     rsp_q;
  logic           run, zfill, en;
  logic [1:0]     req, gnt;
  ram_cmd_t       cmd, m0_cmd, m1_cmd;

  // armed keeps the RAM port and grants quiet while reset is held and until the first edge after release
  assign run   = armed && (state == ST_RUN);
  assign zfill = armed && (state == ST_INIT);
  assign req   = {bus.m1_req_i, bus.m0_req_i};
  assign gnt[0] = run & req[0] & (~req[1] | ~prio);
  assign gnt[1] = run & req[1] & (~req[0] |  prio);

  assign m0_cmd = '{addr: bus.m0_addr_i, we: bus.m0_we_i, be: bus.m0_be_i, wdata: bus.m0_wdata_i};
  assign m1_cmd = '{addr: bus.m1_addr_i, we: bus.m1_we_i, be: bus.m1_be_i, wdata: bus.m1_wdata_i};

  always_comb begin
    cmd = '0;
    en  = 1'b0;
    if (zfill) begin
      en       = 1'b1;
      cmd.addr = ADDR_WIDTH'(32'(cnt) * BE_W);
      cmd.we   = 1'b1;
      cmd.be   = '1;
    end else if (gnt[0]) begin
      en  = 1'b1;
      cmd = m0_cmd;
    end else if (gnt[1]) begin
      en  = 1'b1;
      cmd = m1_cmd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RST;
      armed <= 1'b0;
      cnt   <= '0;
      prio  <= 1'b0;
      rsp_q <= 2'b00;
    end else begin
      armed <= 1'b1;
      rsp_q <= gnt;
      if (gnt[0])      prio <= 1'b1;
      else if (gnt[1]) prio <= 1'b0;
      if (zfill) begin
        if (cnt == CNT_W'(W - 1)) begin
          state <= ST_RUN;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.m0_gnt_o    = gnt[0];
  assign bus.m1_gnt_o    = gnt[1];
  assign bus.m0_rvalid_o = rsp_q[0];
  assign bus.m1_rvalid_o = rsp_q[1];
  assign bus.m0_rdata_o  = rsp_q[0] ? bus.ram_rdata_i : '0;
  assign bus.m1_rdata_o  = rsp_q[1] ? bus.ram_rdata_i : '0;
  assign bus.ram_en_o    = en;
  assign bus.ram_addr_o  = cmd.addr;
  assign bus.ram_we_o    = cmd.we;
  assign bus.ram_be_o    = cmd.be;
  assign bus.ram_wdata_o = cmd.wdata;
  assign bus.init_done_o = run;
endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter: zero-fill and reset restart, then a per-cycle vector table.
module tb_sp_ram_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fill = 1'b1;
  logic [31:0] ram_q = '0;
  logic [31:0] mem [8192];
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sp_ram_arbiter_if #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) bus ();
  sp_ram_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // behavioural RAM, pre-filled with a non-zero pattern so the zero-fill is observable
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 32'hA5A5_A5A5;
    end else if (bus.ram_en_o) begin
      if (bus.ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_be_o[b]) mem[bus.ram_addr_o[14:2]][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
      end else begin
        ram_q <= mem[bus.ram_addr_o[14:2]];
      end
    end
  end
  assign bus.ram_rdata_i = ram_q;

  typedef struct {
    logic r0; logic w0; logic [14:0] a0; logic [3:0] b0; logic [31:0] d0;
    logic r1; logic w1; logic [14:0] a1; logic [3:0] b1; logic [31:0] d1;
    logic g0; logic g1; logic v0; logic v1; logic en; logic we; logic [14:0] addr;
    logic c0; logic [31:0] rd0; logic c1; logic [31:0] rd1;
  } vec_t;

  localparam int NV = 18;
  vec_t vec [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    bus.m0_req_i = v.r0; bus.m0_we_i = v.w0; bus.m0_addr_i = v.a0; bus.m0_be_i = v.b0; bus.m0_wdata_i = v.d0;
    bus.m1_req_i = v.r1; bus.m1_we_i = v.w1; bus.m1_addr_i = v.a1; bus.m1_be_i = v.b1; bus.m1_wdata_i = v.d1;
  endtask

  initial begin
    int n;
    logic early_done;
    //          m0: req we addr be wdata       m1: req we addr be wdata   g0 g1 v0 v1 en we addr  c0 rd0 c1 rd1
    vec[0]  = '{0,0,15'h0000,4'h0,32'h0,       1,0,15'h04,4'h0,32'h0,     0,1,0,0,1,0,15'h04, 1,32'h0,1,32'h0};
    vec[1]  = '{0,0,15'h0000,4'h0,32'h0,       1,0,15'h08,4'h0,32'h0,     0,1,0,1,1,0,15'h08, 1,32'h0,1,32'h0};
    vec[2]  = '{0,0,15'h0000,4'h0,32'h0,       1,0,15'h0C,4'h0,32'h0,     0,1,0,1,1,0,15'h0C, 1,32'h0,1,32'h0};
    vec[3]  = '{0,0,15'h0000,4'h0,32'h0,       1,0,15'h10,4'h0,32'h0,     0,1,0,1,1,0,15'h10, 1,32'h0,1,32'h0};
    vec[4]  = '{1,1,15'h0020,4'hF,32'hDEADBEEF,0,0,15'h00,4'h0,32'h0,     1,0,0,1,1,1,15'h20, 1,32'h0,1,32'h0};
    vec[5]  = '{0,0,15'h0000,4'h0,32'h0,       1,0,15'h20,4'h0,32'h0,     0,1,1,0,1,0,15'h20, 0,32'h0,1,32'h0};
    vec[6]  = '{1,0,15'h0020,4'h0,32'h0,       1,0,15'h24,4'h0,32'h0,     1,0,0,1,1,0,15'h20, 1,32'h0,1,32'hDEADBEEF};
    vec[7]  = '{1,0,15'h0028,4'h0,32'h0,       1,0,15'h24,4'h0,32'h0,     0,1,1,0,1,0,15'h24, 1,32'hDEADBEEF,1,32'h0};
    vec[8]  = '{1,0,15'h0028,4'h0,32'h0,       1,0,15'h2C,4'h0,32'h0,     1,0,0,1,1,0,15'h28, 1,32'h0,1,32'h0};
    vec[9]  = '{1,0,15'h0030,4'h0,32'h0,       1,0,15'h2C,4'h0,32'h0,     0,1,1,0,1,0,15'h2C, 1,32'h0,1,32'h0};
    vec[10] = '{0,1,15'h7FF0,4'hF,32'h12345678,0,1,15'h55,4'hF,32'h9ABC,  0,0,0,1,0,0,15'h00, 1,32'h0,1,32'h0};
    vec[11] = '{1,1,15'h0040,4'h4,32'h00AB0000,0,0,15'h00,4'h0,32'h0,     1,0,0,0,1,1,15'h40, 1,32'h0,1,32'h0};
    vec[12] = '{1,0,15'h0040,4'h0,32'h0,       0,0,15'h00,4'h0,32'h0,     1,0,1,0,1,0,15'h40, 0,32'h0,1,32'h0};
    vec[13] = '{0,0,15'h0000,4'h0,32'h0,       0,0,15'h00,4'h0,32'h0,     0,0,1,0,0,0,15'h00, 1,32'h00AB0000,1,32'h0};
    vec[14] = '{0,0,15'h0000,4'h0,32'h0,       0,0,15'h00,4'h0,32'h0,     0,0,0,0,0,0,15'h00, 1,32'h0,1,32'h0};
    vec[15] = '{1,0,15'h0000,4'h0,32'h0,       1,0,15'h04,4'h0,32'h0,     0,1,0,0,1,0,15'h04, 1,32'h0,1,32'h0};
    vec[16] = '{1,0,15'h0000,4'h0,32'h0,       0,0,15'h00,4'h0,32'h0,     1,0,0,1,1,0,15'h00, 1,32'h0,1,32'h0};
    vec[17] = '{0,0,15'h0000,4'h0,32'h0,       0,0,15'h00,4'h0,32'h0,     0,0,1,0,0,0,15'h00, 1,32'h0,1,32'h0};

    // m0 read of 0x0010 held from reset
    drive('{1,0,15'h0010,4'h0,32'h0, 0,0,15'h0,4'h0,32'h0, 0,0,0,0,0,0,15'h0, 0,32'h0,0,32'h0});
    repeat (2) @(negedge clk);
    fill = 1'b0;
    @(negedge clk);
    chk("rst_gnt0", 32'(bus.m0_gnt_o), 32'd0);
    chk("rst_ram_en", 32'(bus.ram_en_o), 32'd0);
    chk("rst_init_done", 32'(bus.init_done_o), 32'd0);
    chk("rst_rvalid0", 32'(bus.m0_rvalid_o), 32'd0);

    // first zero-fill, interrupted at word 100
    rst_n = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        chk("init0_en", 32'(bus.ram_en_o), 32'd1);
        chk("init0_we", 32'(bus.ram_we_o), 32'd1);
        chk("init0_be", 32'(bus.ram_be_o), 32'hF);
        chk("init0_wdata", bus.ram_wdata_o, 32'd0);
        chk("init0_addr", 32'(bus.ram_addr_o), 32'd0);
      end
    end
    chk("init100_addr", 32'(bus.ram_addr_o), 32'h190);
    chk("init100_gnt0", 32'(bus.m0_gnt_o), 32'd0);
    chk("init100_done", 32'(bus.init_done_o), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_en", 32'(bus.ram_en_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // restarted zero-fill: grant must land exactly 8192 cycles later
    n = 0;
    early_done = 1'b0;
    for (int i = 0; i < 9000; i++) begin
      @(posedge clk); #1;
      n = i;
      if (i == 0) chk("restart_addr", 32'(bus.ram_addr_o), 32'd0);
      if (bus.m0_gnt_o) break;
      if (bus.init_done_o) early_done = 1'b1;
      n = 9000;
    end
    chk("init_gnt_cycle", 32'(n), 32'd8192);
    chk("init_done_early", 32'(early_done), 32'd0);
    chk("run_init_done", 32'(bus.init_done_o), 32'd1);
    chk("first_gnt_addr", 32'(bus.ram_addr_o), 32'h10);
    chk("first_gnt_we", 32'(bus.ram_we_o), 32'd0);
    @(posedge clk); #1;
    bus.m0_req_i = 1'b0;
    chk("first_rvalid0", 32'(bus.m0_rvalid_o), 32'd1);
    chk("first_rvalid1", 32'(bus.m1_rvalid_o), 32'd0);
    chk("first_rdata0", bus.m0_rdata_o, 32'd0);
    @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vec[i]);
      #1;
      chk($sformatf("v%0d_gnt0", i), 32'(bus.m0_gnt_o), 32'(vec[i].g0));
      chk($sformatf("v%0d_gnt1", i), 32'(bus.m1_gnt_o), 32'(vec[i].g1));
      chk($sformatf("v%0d_rvalid0", i), 32'(bus.m0_rvalid_o), 32'(vec[i].v0));
      chk($sformatf("v%0d_rvalid1", i), 32'(bus.m1_rvalid_o), 32'(vec[i].v1));
      chk($sformatf("v%0d_ram_en", i), 32'(bus.ram_en_o), 32'(vec[i].en));
      chk($sformatf("v%0d_ram_we", i), 32'(bus.ram_we_o), 32'(vec[i].we));
      chk($sformatf("v%0d_ram_addr", i), 32'(bus.ram_addr_o), 32'(vec[i].addr));
      if (vec[i].c0) chk($sformatf("v%0d_rdata0", i), bus.m0_rdata_o, vec[i].rd0);
      if (vec[i].c1) chk($sformatf("v%0d_rdata1", i), bus.m1_rdata_o, vec[i].rd1);
    end

    // reset while a response is pending drops it
    @(negedge clk);
    drive('{1,0,15'h0040,4'h0,32'h0, 0,0,15'h0,4'h0,32'h0, 0,0,0,0,0,0,15'h0, 0,32'h0,0,32'h0});
    @(posedge clk); #1;
    bus.m0_req_i = 1'b0;
    chk("pend_rvalid0", 32'(bus.m0_rvalid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("pend_rst_rvalid0", 32'(bus.m0_rvalid_o), 32'd0);
    chk("pend_rst_done", 32'(bus.init_done_o), 32'd0);
    @(posedge clk); #1;
    chk("pend_after_rvalid0", 32'(bus.m0_rvalid_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
